// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage integer execution pipe.
//   S1 registers the decoded ALU operation, operands and tags.
//   S2 registers the computed result and drives the writeback port.
// Both stages use a valid/ready handshake. A flush squashes everything in flight.
// Optional feature macro: ALU_RV64_WORD_EN adds the RV64 *W word ops
// (OP_32 / OP_IMM_32). These ops only take effect when XLEN == 64.
module alu_exec_pipe #(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [PREG_W-1:0]    in_prd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [PREG_W-1:0]    out_prd,
    output logic                 out_illegal
);

    // A 64-bit datapath shifts by up to 63, so it needs one extra shift-amount bit.
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
`ifdef ALU_RV64_WORD_EN
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
`endif

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_op_t;

    // Handshake
    logic s1_adv;
    logic s2_adv;
    logic accept;

    // Decode results (combinational, taken from the issue port)
    alu_op_t        dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_illegal;

    // Stage S1 registers
    logic                 s1_valid;
    alu_op_t              s1_op;
    logic [XLEN-1:0]      s1_a;
    logic [XLEN-1:0]      s1_b;
    logic                 s1_illegal;
    logic [ROB_IDX_W-1:0] s1_rob_idx;
    logic [PREG_W-1:0]    s1_prd;

    // Execute result (combinational, taken from S1)
    logic [XLEN-1:0]    ex_result;
    logic [SHAMT_W-1:0] shamt;

`ifdef ALU_RV64_WORD_EN
    logic        dec_word;
    logic        s1_word;
    logic [31:0] w_res;
`endif

    // Output stage S2 is the out_* register set, so s2_valid is out_valid.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    // During a flush, in_ready may be high but the issued op is dropped.
    assign accept   = in_valid && s1_adv && !flush;

    // Map funct3 onto the base ALU op. 'alt' selects SUB/SRA over ADD/SRL.
    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Decode the opcode fields into an ALU op and select the operands.
    always_comb begin
        dec_op      = ALU_ADD;
        dec_a       = in_rs1;
        dec_b       = in_rs2;
        dec_illegal = 1'b0;
`ifdef ALU_RV64_WORD_EN
        dec_word    = 1'b0;
`endif
        case (in_opcode)
            OPC_OP: begin
                dec_op = base_op(in_funct3, in_funct7[5]);
            end
            OPC_OP_IMM: begin
                // There is no SUBI, so funct7 only matters for the right shifts.
                dec_op = base_op(in_funct3, (in_funct3 == 3'b101) && in_funct7[5]);
                dec_b  = in_imm;
            end
            OPC_LUI: begin
                dec_op = ALU_PASS_B;
                dec_b  = in_imm;
            end
            OPC_AUIPC: begin
                dec_op = ALU_ADD;
                dec_a  = in_pc;
                dec_b  = in_imm;
            end
`ifdef ALU_RV64_WORD_EN
            OPC_OP_32, OPC_OP_IMM_32: begin
                dec_word = 1'b1;
                if (in_opcode == OPC_OP_IMM_32) begin
                    dec_b = in_imm;
                end
                if (XLEN != 64) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (in_funct3)
                        3'b000:  dec_op = ((in_opcode == OPC_OP_32) && in_funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_op = ALU_SLL;
                        3'b101:  dec_op = in_funct7[5] ? ALU_SRA : ALU_SRL;
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
`endif
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // S1: capture the decoded op on accept; a flush empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_op      <= ALU_ADD;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_illegal <= 1'b0;
            s1_rob_idx <= '0;
            s1_prd     <= '0;
`ifdef ALU_RV64_WORD_EN
            s1_word    <= 1'b0;
`endif
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op      <= dec_op;
                s1_a       <= dec_a;
                s1_b       <= dec_b;
                s1_illegal <= dec_illegal;
                s1_rob_idx <= in_rob_idx;
                s1_prd     <= in_prd;
`ifdef ALU_RV64_WORD_EN
                s1_word    <= dec_word;
`endif
            end
        end
    end

    assign shamt = s1_b[SHAMT_W-1:0];

`ifdef ALU_RV64_WORD_EN
    // Word ops: 32-bit arithmetic on the low halves, shift amount limited to 5 bits.
    always_comb begin
        case (s1_op)
            ALU_ADD: w_res = s1_a[31:0] + s1_b[31:0];
            ALU_SUB: w_res = s1_a[31:0] - s1_b[31:0];
            ALU_SLL: w_res = s1_a[31:0] << s1_b[4:0];
            ALU_SRL: w_res = s1_a[31:0] >> s1_b[4:0];
            ALU_SRA: w_res = $signed(s1_a[31:0]) >>> s1_b[4:0];
            default: w_res = '0;
        endcase
    end
`endif

    // Execute the S1 op. An illegal op always yields zero.
    always_comb begin
        ex_result = '0;
        case (s1_op)
            ALU_ADD:    ex_result = s1_a + s1_b;
            ALU_SUB:    ex_result = s1_a - s1_b;
            ALU_XOR:    ex_result = s1_a ^ s1_b;
            ALU_OR:     ex_result = s1_a | s1_b;
            ALU_AND:    ex_result = s1_a & s1_b;
            ALU_SLL:    ex_result = s1_a << shamt;
            ALU_SRL:    ex_result = s1_a >> shamt;
            ALU_SRA:    ex_result = $signed(s1_a) >>> shamt;
            ALU_SLT:    ex_result = XLEN'($signed(s1_a) < $signed(s1_b));
            ALU_SLTU:   ex_result = XLEN'(s1_a < s1_b);
            ALU_PASS_B: ex_result = s1_b;
            default:    ex_result = '0;
        endcase
`ifdef ALU_RV64_WORD_EN
        if (s1_word) begin
            ex_result = XLEN'($signed(w_res));
        end
`endif
        if (s1_illegal) begin
            ex_result = '0;
        end
    end

    // S2: register the result. Outputs stay frozen while the writeback stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rob_idx <= '0;
            out_prd     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= ex_result;
                out_rob_idx <= s1_rob_idx;
                out_prd     <= s1_prd;
                out_illegal <= s1_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Testbench for alu_exec_pipe. It runs directed vectors, hand-written
// handshake, flush and reset sequences, and randomized traffic. A
// scoreboard and a reference model built from the instruction rules check
// every output.
// Define ALU_RV64_WORD_EN to build the bench for XLEN=64 with word ops.
module tb_alu_exec_pipe;

`ifdef ALU_RV64_WORD_EN
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif
    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           in_opcode;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [XLEN-1:0]      in_rs1;
    logic [XLEN-1:0]      in_rs2;
    logic [XLEN-1:0]      in_imm;
    logic [XLEN-1:0]      in_pc;
    logic [ROB_IDX_W-1:0] in_rob_idx;
    logic [PREG_W-1:0]    in_prd;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic [PREG_W-1:0]    out_prd;
    logic                 out_illegal;

    alu_exec_pipe #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob_idx(in_rob_idx), .in_prd(in_prd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rob_idx(out_rob_idx), .out_prd(out_prd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic                 ill;
        logic [XLEN-1:0]      res;
        logic [ROB_IDX_W-1:0] rob;
        logic [PREG_W-1:0]    prd;
    } sb_t;

    sb_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Table constants are 32-bit values, sign-extended to the bench width.
    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Reference ALU for the base ops: plain arithmetic, shift amount taken modulo XLEN.
    function automatic logic [XLEN-1:0] arith(input logic [2:0] f3, input logic alt,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int sh;
        logic [XLEN-1:0] r;
        sh = int'(b % XLEN);
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << sh;
            3'd2:    r = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
            3'd3:    r = (a < b) ? XLEN'(1) : '0;
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? XLEN'($signed(a) >>> sh) : a >> sh;
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Reference model of one instruction: {illegal, result}.
    function automatic sb_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                  input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
        sb_t e;
`ifdef ALU_RV64_WORD_EN
        logic [31:0] a32, b32, r32;
        int sh;
`endif
        e = '0;
        case (op)
            7'h33: e.res = arith(f3, f7[5], rs1, rs2);
            7'h13: e.res = arith(f3, (f3 == 3'd5) && f7[5], rs1, imm);
            7'h37: e.res = imm;
            7'h17: e.res = pc + imm;
`ifdef ALU_RV64_WORD_EN
            7'h3B, 7'h1B: begin
                a32 = rs1[31:0];
                b32 = (op == 7'h3B) ? rs2[31:0] : imm[31:0];
                sh  = int'(b32 % 32);
                r32 = '0;
                case (f3)
                    3'd0:    r32 = (op == 7'h3B && f7[5]) ? a32 - b32 : a32 + b32;
                    3'd1:    r32 = a32 << sh;
                    3'd5:    r32 = f7[5] ? 32'($signed(a32) >>> sh) : a32 >> sh;
                    default: e.ill = 1'b1;
                endcase
                if (!e.ill) e.res = XLEN'($signed(r32));
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                          input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] prd);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = im; in_pc = p;
        in_rob_idx = rob; in_prd = prd;
    endtask

    task automatic set_vec(input vec_t v, input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] prd);
        set_in(v.op, v.f3, v.f7, sx(v.rs1), sx(v.rs2), sx(v.imm), sx(v.pc), rob, prd);
    endtask

    // Hold in_valid until accepted, then drop it just after the accepting edge.
    task automatic send_vec(input vec_t v, input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] prd);
        int n;
        set_vec(v, rob, prd);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_wait_ready");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted ops, compare completed transfers, check stall hold.
    initial begin : monitor
        sb_t e;
        logic prev_stall;
        logic [XLEN-1:0] h_res;
        logic [ROB_IDX_W-1:0] h_rob;
        logic [PREG_W-1:0] h_prd;
        logic h_ill;
        prev_stall = 1'b0;
        h_res = '0; h_rob = '0; h_prd = '0; h_ill = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_result", 64'(out_result), 64'(h_res));
                    chk("hold_tags", 64'({out_rob_idx, out_prd, out_illegal}), 64'({h_rob, h_prd, h_ill}));
                end
                prev_stall = out_valid && !out_ready && !flush;
                h_res = out_result; h_rob = out_rob_idx; h_prd = out_prd; h_ill = out_illegal;
                if (flush) begin
                    sb_q.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_unexpected_output", 64'(out_result), 64'hDEAD);
                            errors += (out_result == 'hDEAD) ? 1 : 0;
                        end else begin
                            e = sb_q.pop_front();
                            chk("sb_result", 64'(out_result), 64'(e.res));
                            chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
                            chk("sb_tags", 64'({out_rob_idx, out_prd}), 64'({e.rob, e.prd}));
                        end
                    end
                    if (in_valid && in_ready) begin
                        e = model(in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc);
                        e.rob = in_rob_idx;
                        e.prd = in_prd;
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[18];
    vec_t bb[4];

    function automatic logic [XLEN-1:0] rnd_val();
        logic [XLEN-1:0] r;
        case ($urandom_range(0, 7))
            0:       r = '0;
            1:       r = '1;
            2:       r = XLEN'(1);
            3:       r = {1'b1, {(XLEN-1){1'b0}}};
            default: r = XLEN'({$urandom(), $urandom()});
        endcase
        return r;
    endfunction

    initial begin : stim
        int n;
        logic [6:0] opc;
        //            op     f3    f7     rs1           rs2           imm           pc            exp           ill
        vecs[0]  = '{7'h33, 3'd0, 7'h20, 32'd10,       32'd3,        32'd0,        32'd0,        32'd7,        1'b0};
        vecs[1]  = '{7'h33, 3'd0, 7'h00, 32'd10,       32'd3,        32'd0,        32'd0,        32'd13,       1'b0};
        vecs[2]  = '{7'h13, 3'd0, 7'h20, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,        32'd4,        1'b0};
        vecs[3]  = '{7'h33, 3'd4, 7'h00, 32'hF0,       32'hFF,       32'd0,        32'd0,        32'h0F,       1'b0};
        vecs[4]  = '{7'h33, 3'd6, 7'h00, 32'hF0,       32'h0F,       32'd0,        32'd0,        32'hFF,       1'b0};
        vecs[5]  = '{7'h33, 3'd7, 7'h00, 32'hF0,       32'h3C,       32'd0,        32'd0,        32'h30,       1'b0};
        vecs[6]  = '{7'h33, 3'd1, 7'h00, 32'd3,        32'd4,        32'd0,        32'd0,        32'h30,       1'b0};
        vecs[7]  = '{7'h33, 3'd5, 7'h00, 32'hF0,       32'd4,        32'd0,        32'd0,        32'h0F,       1'b0};
        vecs[8]  = '{7'h33, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,        32'd0,        32'hF8000000, 1'b0};
        vecs[9]  = '{7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd1,        1'b0};
        vecs[10] = '{7'h33, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd1,        1'b0};
        vecs[11] = '{7'h33, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        1'b0};
        vecs[12] = '{7'h37, 3'd0, 7'h00, 32'd0,        32'd0,        32'h12345000, 32'd0,        32'h12345000, 1'b0};
        vecs[13] = '{7'h17, 3'd0, 7'h00, 32'd0,        32'd0,        32'h2000,     32'h1000,     32'h3000,     1'b0};
        vecs[14] = '{7'h7F, 3'd0, 7'h00, 32'd5,        32'd6,        32'd7,        32'd0,        32'd0,        1'b1};
`ifdef ALU_RV64_WORD_EN
        vecs[15] = '{7'h3B, 3'd0, 7'h00, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        32'h80000000, 1'b0};
        vecs[16] = '{7'h1B, 3'd1, 7'h00, 32'd1,        32'd0,        32'd31,       32'd0,        32'h80000000, 1'b0};
`else
        vecs[15] = '{7'h3B, 3'd0, 7'h00, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        1'b1};
        vecs[16] = '{7'h1B, 3'd1, 7'h00, 32'd1,        32'd0,        32'd31,       32'd0,        32'd0,        1'b1};
`endif
        vecs[17] = '{7'h3B, 3'd2, 7'h00, 32'd1,        32'd2,        32'd0,        32'd0,        32'd0,        1'b1};

        bb[0] = '{7'h13, 3'd0, 7'h00, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0, 32'd4,        1'b0};
        bb[1] = '{7'h13, 3'd4, 7'h00, 32'hF0,       32'd0,        32'hFF,       32'd0, 32'h0F,       1'b0};
        bb[2] = '{7'h33, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0, 32'd1,        1'b0};
        bb[3] = '{7'h33, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,        32'd0, 32'hF8000000, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(7'h33, 3'd0, 7'h00, '0, '0, '0, '0, '0, '0);
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", 64'(out_result), 64'd0);
        chk("reset_out_tags", 64'({out_rob_idx, out_prd, out_illegal}), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        next_cycle();

        // Directed vectors, one at a time: latency, result and tag echo.
        for (int i = 0; i < 18; i++) begin
            send_vec(vecs[i], ROB_IDX_W'(i), PREG_W'(i + 32));
            @(negedge clk);
            chk("vec_latency_early", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_result", 64'(out_result), 64'(sx(vecs[i].exp)));
            chk("vec_illegal", 64'(out_illegal), 64'(vecs[i].ill));
            chk("vec_tags", 64'({out_rob_idx, out_prd}), 64'({ROB_IDX_W'(i), PREG_W'(i + 32)}));
            $display("vec %0d op=%h f3=%0d result=%h illegal=%0d", i, vecs[i].op, vecs[i].f3, out_result, out_illegal);
            next_cycle();
        end

        // Back-to-back stream: one result per cycle, two cycles after issue.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_vec(bb[k], ROB_IDX_W'(k + 20), PREG_W'(k + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 4) chk("b2b_in_ready", 64'(in_ready), 64'd1);
            if (k >= 2) begin
                chk("b2b_out_valid", 64'(out_valid), 64'd1);
                chk("b2b_result", 64'(out_result), 64'(sx(bb[k-2].exp)));
                $display("b2b cycle %0d result=%h", k, out_result);
            end
            next_cycle();
        end
        in_valid = 1'b0;

        // Backpressure: two ops fill the pipe, the third must wait, and all drain in order.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_vec(bb[k < 3 ? k : 2], ROB_IDX_W'(k), PREG_W'(k));
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
            if (k >= 2) chk("bp_hold_result", 64'(out_result), 64'(sx(bb[0].exp)));
            $display("bp cycle %0d in_ready=%0d out_valid=%0d", k, in_ready, out_valid);
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_drain_valid", 64'(out_valid), 64'd1);
            chk("bp_drain_result", 64'(out_result), 64'(sx(bb[k].exp)));
            $display("bp drain %0d result=%h", k, out_result);
            next_cycle();
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_drain_empty", 64'(out_valid), 64'd0);
        next_cycle();

        // Flush with both stages full and an op offered.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_vec(vecs[k], ROB_IDX_W'(k), PREG_W'(k));
            in_valid = 1'b1;
            flush = (k == 2);
            @(negedge clk);
            if (k == 2) chk("flush_full_before", 64'(out_valid), 64'd1);
            next_cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_no_output", 64'(out_valid), 64'd0);
            next_cycle();
        end
        $display("flush with full pipe: no output after flush");
        // Flush with an empty pipe and in_ready high: the offered op is dropped.
        set_vec(vecs[1], 5'd9, 6'd9);
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_drop", 64'(out_valid), 64'd0);
            next_cycle();
        end
        send_vec(vecs[13], 5'd17, 6'd17);
        @(negedge clk);
        @(negedge clk);
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_result", 64'(out_result), 64'h3000);
        $display("post-flush op result=%h", out_result);
        next_cycle();

        // Reset while an op sits in the output stage.
        send_vec(vecs[0], 5'd3, 6'd3);
        next_cycle();
        chk("rst_mid_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(out_result), 64'd0);
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_output", 64'(out_valid), 64'd0);
            next_cycle();
        end
        $display("reset mid-operation: no partial result");

        // Randomized traffic against the scoreboard model.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 6))
                0: opc = 7'h33;
                1: opc = 7'h13;
                2: opc = 7'h37;
                3: opc = 7'h17;
                4: opc = 7'h3B;
                5: opc = 7'h1B;
                default: opc = 7'($urandom());
            endcase
            set_in(opc, 3'($urandom()), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                   rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                   ROB_IDX_W'($urandom()), PREG_W'($urandom()));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            next_cycle();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            next_cycle();
            n++;
        end
        chk("random_drain_empty", 64'(sb_q.size()), 64'd0);
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
